// File: rtl/pe_psum_collector.sv
// pe_psum_collector
//   Bottom-of-column collector for a systolic PE. It takes the signed products
//   the PE emits, one per accepted cycle, and adds ACC_LEN of them into one
//   partial sum. Finished sums queue in a small FIFO. The FIFO drains over a
//   valid/ready port to the output writer.
//   If the FIFO is full when a window completes, the sum waits in a holding
//   register (state HOLD). Input is stalled until a FIFO slot opens.
//   Build option: define ACC_SAT_EN to make every addition saturate to the
//   signed ACC_BW range and to raise the sticky o_sat flag. Without it, sums
//   wrap and o_sat is tied low.
module pe_psum_collector #(
  parameter int M_BW       = 16,
  parameter int ACC_BW     = 24,
  parameter int ACC_LEN    = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          en_clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          i_mul_valid,
  input  logic [M_BW-1:0]               i_mul_result,
  output logic                          o_in_ready,
  output logic                          o_acc_valid,
  output logic [ACC_BW-1:0]             o_acc_data,
  input  logic                          i_acc_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
  output logic                          o_busy,
  output logic                          o_sat
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = $clog2(ACC_LEN);
  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(ACC_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_BW-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [ACC_BW-1:0]   hold_q, hold_d;

  logic [ACC_BW-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q, rd_next;
  logic [CNT_W-1:0]    cnt_q;
  logic [ACC_BW-1:0]   head_q, head_d;

  logic                accept;
  logic                push, pop, fifo_space;
  logic [ACC_BW-1:0]   push_data;
  logic [ACC_BW-1:0]   prod_ext;
  logic [ACC_BW-1:0]   acc_sum;

  // Ready is low while reset is held, during a clr cycle, and while a sum waits in HOLD.
  assign o_in_ready = rst_n & ~clr & (state_q != ST_HOLD);
  assign accept     = i_mul_valid & o_in_ready;

  assign o_acc_valid = (cnt_q != '0);
  assign o_acc_data  = head_q;
  assign o_fifo_cnt  = cnt_q;
  assign o_busy      = (state_q == ST_ACC) || (state_q == ST_HOLD);

  assign pop        = o_acc_valid & i_acc_ready;
  assign fifo_space = (cnt_q != FULL_CNT) | pop;
  assign rd_next    = rd_ptr_q + PTR_W'(1);

  assign prod_ext = {{(ACC_BW - M_BW){i_mul_result[M_BW-1]}}, i_mul_result};

`ifdef ACC_SAT_EN
  localparam logic [ACC_BW-1:0] SAT_MAX = {1'b0, {(ACC_BW - 1){1'b1}}};
  localparam logic [ACC_BW-1:0] SAT_MIN = {1'b1, {(ACC_BW - 1){1'b0}}};

  logic [ACC_BW:0] wide_sum;
  logic            overflow;
  logic            sat_q;

  assign wide_sum = {acc_q[ACC_BW-1], acc_q} + {prod_ext[ACC_BW-1], prod_ext};
  assign overflow = wide_sum[ACC_BW] ^ wide_sum[ACC_BW-1];

  // Clip the sum to the signed range when the extra sign bit disagrees with the result sign.
  always_comb begin
    acc_sum = wide_sum[ACC_BW-1:0];
    if (overflow) begin
      acc_sum = wide_sum[ACC_BW] ? SAT_MIN : SAT_MAX;
    end
  end

  // Sticky clip flag; only reset or clr clears it.
  always_ff @(posedge en_clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (clr) begin
      sat_q <= 1'b0;
    end else if (accept && overflow) begin
      sat_q <= 1'b1;
    end
  end

  assign o_sat = sat_q;
`else
  assign acc_sum = acc_q + prod_ext;
  assign o_sat   = 1'b0;
`endif

  // Window FSM: next state, accumulator update, and the single FIFO push source.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    hold_d    = hold_q;
    push      = 1'b0;
    push_data = acc_sum;
    if (clr) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            acc_d   = acc_sum;
            count_d = LEN_W'(1);
            state_d = ST_ACC;
          end
        end
        ST_ACC: begin
          if (accept) begin
            if (count_q == LAST_IDX) begin
              acc_d   = '0;
              count_d = '0;
              if (fifo_space) begin
                push    = 1'b1;
                state_d = ST_IDLE;
              end else begin
                hold_d  = acc_sum;
                state_d = ST_HOLD;
              end
            end else begin
              acc_d   = acc_sum;
              count_d = count_q + LEN_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (fifo_space) begin
            push      = 1'b1;
            push_data = hold_q;
            state_d   = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM, accumulator and holding-register state.
  always_ff @(posedge en_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  end

  // Next registered head: a push into an empty (or emptying) FIFO becomes the head,
  // a pop moves to the following entry, and the last popped value stays when empty.
  always_comb begin
    head_d = head_q;
    if (push && ((cnt_q == '0) || ((cnt_q == CNT_W'(1)) && pop))) begin
      head_d = push_data;
    end else if (pop && (cnt_q > CNT_W'(1))) begin
      head_d = mem[rd_next];
    end
  end

  // FIFO storage; entries are only ever read after being written, so no reset.
  always_ff @(posedge en_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // FIFO pointers, occupancy and registered head.
  always_ff @(posedge en_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_next;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      head_q <= head_d;
    end
  end

endmodule

// File: tb/tb_pe_psum_collector.sv
// Testbench for pe_psum_collector.
// It runs a default-width instance and an ACC_BW=18 instance side by side.
// Both instances receive the same stimulus.
// Expected values are hand-computed, and table vectors cover whole windows.
module tb_pe_psum_collector;

  logic        en_clk;
  logic        rst_n;
  logic        clr;
  logic        i_mul_valid;
  logic [15:0] i_mul_result;
  logic        i_acc_ready;

  logic        o_in_ready;
  logic        o_acc_valid;
  logic [23:0] o_acc_data;
  logic [2:0]  o_fifo_cnt;
  logic        o_busy;
  logic        o_sat;

  logic        in_ready18;
  logic        acc_valid18;
  logic [17:0] acc_data18;
  logic [2:0]  fifo_cnt18;
  logic        busy18;
  logic        sat18;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int start;
    int step;
    bit alt;
    bit gap;
    int expected;
  } vec_t;

  vec_t vecs[7];
  int   ord_exp[3];
  int   pops;
  int   exp18;
  int   expsat;

  pe_psum_collector u_dut (
    .en_clk       (en_clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .i_mul_valid  (i_mul_valid),
    .i_mul_result (i_mul_result),
    .o_in_ready   (o_in_ready),
    .o_acc_valid  (o_acc_valid),
    .o_acc_data   (o_acc_data),
    .i_acc_ready  (i_acc_ready),
    .o_fifo_cnt   (o_fifo_cnt),
    .o_busy       (o_busy),
    .o_sat        (o_sat)
  );

  pe_psum_collector #(.ACC_BW(18)) u_dut18 (
    .en_clk       (en_clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .i_mul_valid  (i_mul_valid),
    .i_mul_result (i_mul_result),
    .o_in_ready   (in_ready18),
    .o_acc_valid  (acc_valid18),
    .o_acc_data   (acc_data18),
    .i_acc_ready  (i_acc_ready),
    .o_fifo_cnt   (fifo_cnt18),
    .o_busy       (busy18),
    .o_sat        (sat18)
  );

  initial begin
    en_clk = 1'b0;
    forever #5 en_clk = ~en_clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic signed [31:0] act,
                             input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge en_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input int d);
    logic [31:0] dv;
    dv           = d;
    i_mul_valid  = v;
    i_mul_result = dv[15:0];
    tick();
  endtask

  task automatic sendWindow(input int start, input int step, input bit alt, input bit gap);
    int p;
    for (int k = 0; k < 9; k++) begin
      if (alt) p = (k % 2 == 0) ? start : -start;
      else     p = start + k * step;
      applyStimulus(1'b1, p);
      if (gap && k < 8) applyStimulus(1'b0, 0);
    end
    i_mul_valid  = 1'b0;
    i_mul_result = '0;
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{start: 1,      step: 1,    alt: 1'b0, gap: 1'b0, expected: 45};
    vecs[1] = '{start: -32768, step: 0,    alt: 1'b0, gap: 1'b0, expected: -294912};
    vecs[2] = '{start: 5,      step: 0,    alt: 1'b1, gap: 1'b0, expected: 5};
    vecs[3] = '{start: 2,      step: 0,    alt: 1'b0, gap: 1'b1, expected: 18};
    vecs[4] = '{start: -100,   step: 25,   alt: 1'b0, gap: 1'b0, expected: 0};
    vecs[5] = '{start: 1000,   step: -300, alt: 1'b0, gap: 1'b1, expected: -1800};
    vecs[6] = '{start: 32767,  step: 0,    alt: 1'b0, gap: 1'b0, expected: 294903};
    ord_exp[0] = 9;
    ord_exp[1] = 18;
    ord_exp[2] = 27;
`ifdef ACC_SAT_EN
    exp18  = 131071;
    expsat = 1;
`else
    exp18  = 32759;
    expsat = 0;
`endif

    rst_n        = 1'b0;
    clr          = 1'b0;
    i_mul_valid  = 1'b0;
    i_mul_result = '0;
    i_acc_ready  = 1'b1;

    // Outputs while reset is held.
    #2;
    checkOutput("reset in_ready", o_in_ready, 0);
    checkOutput("reset acc_valid", o_acc_valid, 0);
    checkOutput("reset acc_data", $signed(o_acc_data), 0);
    checkOutput("reset fifo_cnt", o_fifo_cnt, 0);
    checkOutput("reset busy", o_busy, 0);
    checkOutput("reset sat", o_sat, 0);
    #10;
    rst_n = 1'b1;
    tick();
    checkOutput("post-reset in_ready", o_in_ready, 1);

    // Products 1..9: busy through the window, sum visible right after the 9th accept.
    $display("[TB] products 1..9 latency and busy");
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(1'b1, k);
      if (k < 9) begin
        checkOutput($sformatf("win busy k=%0d", k), o_busy, 1);
        checkOutput($sformatf("win valid k=%0d", k), o_acc_valid, 0);
      end
    end
    i_mul_valid = 1'b0;
    checkOutput("win busy end", o_busy, 0);
    checkOutput("win valid end", o_acc_valid, 1);
    checkOutput("win data", $signed(o_acc_data), 45);
    tick();
    checkOutput("win popped", o_acc_valid, 0);
    checkOutput("win data held", $signed(o_acc_data), 45);

    // Table of whole windows with downstream always ready.
    $display("[TB] table vectors");
    for (int i = 0; i < 7; i++) begin
      sendWindow(vecs[i].start, vecs[i].step, vecs[i].alt, vecs[i].gap);
      checkOutput($sformatf("vec%0d valid", i), o_acc_valid, 1);
      checkOutput($sformatf("vec%0d data", i), $signed(o_acc_data), vecs[i].expected);
      checkOutput($sformatf("vec%0d sat", i), o_sat, 0);
      tick();
      checkOutput($sformatf("vec%0d drained", i), o_fifo_cnt, 0);
    end

    // Narrow accumulator: 9 x 32767 overflows 18 bits.
    $display("[TB] 18-bit overflow");
    pulseClr();
    checkOutput("n18 sat cleared", sat18, 0);
    sendWindow(32767, 0, 1'b0, 1'b0);
    checkOutput("n18 valid", acc_valid18, 1);
    checkOutput("n18 data", $signed(acc_data18), exp18);
    checkOutput("n18 sat", sat18, expsat);
    checkOutput("n24 data", $signed(o_acc_data), 294903);
    tick();
    checkOutput("n18 sat sticky", sat18, expsat);
    pulseClr();
    checkOutput("n18 sat after clr", sat18, 0);

    // Backpressure: four sums fill the FIFO, the fifth waits in HOLD.
    $display("[TB] backpressure and HOLD");
    i_acc_ready = 1'b0;
    for (int w = 1; w <= 5; w++) begin
      sendWindow(1, 0, 1'b0, 1'b0);
      if (w < 5) checkOutput($sformatf("bp cnt w=%0d", w), o_fifo_cnt, w);
    end
    checkOutput("bp hold in_ready", o_in_ready, 0);
    checkOutput("bp hold busy", o_busy, 1);
    checkOutput("bp hold cnt", o_fifo_cnt, 4);
    checkOutput("bp head", $signed(o_acc_data), 9);
    i_acc_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 10; c++) begin
      if (o_acc_valid) begin
        checkOutput($sformatf("bp drain %0d", pops), $signed(o_acc_data), 9);
        pops++;
      end
      tick();
      if (c == 0) begin
        checkOutput("bp hold exit busy", o_busy, 0);
        checkOutput("bp hold exit cnt", o_fifo_cnt, 4);
      end
    end
    checkOutput("bp pop count", pops, 5);
    checkOutput("bp empty", o_fifo_cnt, 0);
    checkOutput("bp ready again", o_in_ready, 1);

    // FIFO order with distinct sums.
    $display("[TB] FIFO order");
    i_acc_ready = 1'b0;
    sendWindow(1, 0, 1'b0, 1'b0);
    sendWindow(2, 0, 1'b0, 1'b0);
    sendWindow(3, 0, 1'b0, 1'b0);
    checkOutput("ord cnt", o_fifo_cnt, 3);
    i_acc_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("ord valid %0d", i), o_acc_valid, 1);
      checkOutput($sformatf("ord data %0d", i), $signed(o_acc_data), ord_exp[i]);
      tick();
    end
    checkOutput("ord empty", o_acc_valid, 0);

    // clr mid-window discards the partial sum.
    $display("[TB] clr mid-window");
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 7);
    checkOutput("clr busy before", o_busy, 1);
    clr          = 1'b1;
    i_mul_valid  = 1'b1;
    i_mul_result = 16'd7;
    #1;
    checkOutput("clr in_ready", o_in_ready, 0);
    tick();
    clr         = 1'b0;
    i_mul_valid = 1'b0;
    checkOutput("clr busy after", o_busy, 0);
    checkOutput("clr cnt after", o_fifo_cnt, 0);
    sendWindow(2, 0, 1'b0, 1'b0);
    checkOutput("clr new valid", o_acc_valid, 1);
    checkOutput("clr new data", $signed(o_acc_data), 18);
    tick();
    checkOutput("clr no stale", o_acc_valid, 0);

    // Asynchronous reset while in HOLD with a full FIFO.
    $display("[TB] reset in HOLD");
    i_acc_ready = 1'b0;
    for (int w = 0; w < 5; w++) sendWindow(1, 0, 1'b0, 1'b0);
    checkOutput("rh hold busy", o_busy, 1);
    checkOutput("rh full", o_fifo_cnt, 4);
    rst_n = 1'b0;
    #1;
    checkOutput("rh acc_valid", o_acc_valid, 0);
    checkOutput("rh fifo_cnt", o_fifo_cnt, 0);
    checkOutput("rh busy", o_busy, 0);
    checkOutput("rh in_ready", o_in_ready, 0);
    #3;
    rst_n = 1'b1;
    tick();
    checkOutput("rh ready after", o_in_ready, 1);
    checkOutput("rh valid after", o_acc_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
